// File: rtl/led_blink_arbiter.sv
// Two-source LED blink-code player: plays N lit pulses separated by dark gaps,
// then a trailing dark gap. The high source wins ties, and a playing code is never preempted.
module led_blink_arbiter #(
   parameter int TICK_DIV  = 50_000,
   parameter int ON_TICKS  = 200,
   parameter int OFF_TICKS = 200,
   parameter int GAP_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hi_valid,
   input  logic [3:0] hi_count,
   output logic       hi_ready,
   input  logic       lo_valid,
   input  logic [3:0] lo_count,
   output logic       lo_ready,
   output logic       led,
   output logic       busy,
   output logic       active_src,
   output logic       done
);

   localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0]     ON_LAST    = 16'(ON_TICKS - 1);
   localparam logic [15:0]     OFF_LAST   = 16'(OFF_TICKS - 1);
   localparam logic [15:0]     GAP_LAST   = 16'(GAP_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [15:0]     r_phase;
   logic [3:0]      r_remaining;
   logic            r_led;
   logic            r_busy;
   logic            r_done;
   logic            r_src;

   logic            w_idle;
   logic            w_hi_acc;
   logic            w_lo_acc;
   logic            w_accept;
   logic [3:0]      w_acc_count;
   logic            w_tick;
   logic [15:0]     w_phase_last;
   logic            w_phase_end;

   assign w_idle      = (r_state == S_IDLE);
   assign hi_ready    = rst_n & w_idle;
   assign lo_ready    = rst_n & w_idle & ~hi_valid;
   assign w_hi_acc    = hi_valid & hi_ready;
   assign w_lo_acc    = lo_valid & lo_ready;
   assign w_accept    = w_hi_acc | w_lo_acc;
   assign w_acc_count = w_hi_acc ? hi_count : lo_count;
   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_phase_end = w_tick & (r_phase == w_phase_last);

   assign led        = r_led;
   assign busy       = r_busy;
   assign active_src = r_src;
   assign done       = r_done;

   always_comb begin
      w_phase_last = ON_LAST;
      case (r_state)
         S_OFF:   w_phase_last = OFF_LAST;
         S_GAP:   w_phase_last = GAP_LAST;
         default: w_phase_last = ON_LAST;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept && (w_acc_count != 4'd0)) w_state_nxt = S_ON;
         S_ON:   if (w_phase_end) w_state_nxt = (r_remaining > 4'd1) ? S_OFF : S_GAP;
         S_OFF:  if (w_phase_end) w_state_nxt = S_ON;
         S_GAP:  if (w_phase_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Outputs are registered from the next state so led tracks the phase with no extra lag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc     <= '0;
         r_phase     <= '0;
         r_remaining <= '0;
         r_led       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_src       <= 1'b0;
      end else begin
         r_led  <= (w_state_nxt == S_ON);
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (r_state == S_GAP) && (w_state_nxt == S_IDLE);

         if (w_accept) begin
            r_remaining <= w_acc_count;
            r_src       <= w_hi_acc;
         end else if ((r_state == S_ON) && (w_state_nxt == S_OFF)) begin
            r_remaining <= r_remaining - 4'd1;
         end

         if (w_idle || w_tick) r_presc <= '0;
         else                  r_presc <= r_presc + 1'b1;

         // Phase count restarts on every state change; a phase ends before it can pass its limit.
         if (w_idle || (w_state_nxt != r_state)) r_phase <= '0;
         else if (w_tick)                        r_phase <= r_phase + 16'd1;
      end
   end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: an elapsed-time model checked every cycle,
// plus directed scenarios with hand-computed durations.
module tb_led_blink_arbiter;

   localparam int TD   = 4;
   localparam int ONT  = 2;
   localparam int OFFT = 1;
   localparam int GAPT = 3;
   localparam int ONC  = ONT * TD;
   localparam int OFFC = OFFT * TD;
   localparam int GAPC = GAPT * TD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hi_valid = 1'b0;
   logic [3:0] hi_count = 4'd0;
   logic       lo_valid = 1'b0;
   logic [3:0] lo_count = 4'd0;
   logic       hi_ready, lo_ready, led, busy, active_src, done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_blink_arbiter #(
      .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .hi_valid(hi_valid), .hi_count(hi_count), .hi_ready(hi_ready),
      .lo_valid(lo_valid), .lo_count(lo_count), .lo_ready(lo_ready),
      .led(led), .busy(busy), .active_src(active_src), .done(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: a code is described by its start edge and N; outputs follow from elapsed clocks.
   bit m_valid = 0, m_play = 0, m_done = 0, m_src = 0;
   int m_d = 0, m_N = 0, m_T = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1; m_play = 0; m_done = 0; m_src = 0; m_d = 0;
      end else begin
         m_done = 0;
         if (m_play) begin
            m_d++;
            if (m_d == m_T) begin m_play = 0; m_done = 1; end
         end else if (hi_valid || lo_valid) begin
            m_src = hi_valid;
            m_N   = hi_valid ? int'(hi_count) : int'(lo_count);
            if (m_N > 0) begin
               m_play = 1; m_d = 0;
               m_T = m_N * ONC + (m_N - 1) * OFFC + GAPC;
            end
         end
      end
   end

   function automatic bit exp_led();
      return m_play && (m_d < m_N * ONC + (m_N - 1) * OFFC) && ((m_d % (ONC + OFFC)) < ONC);
   endfunction

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         check("m_led",      led,        exp_led());
         check("m_busy",     busy,       m_play);
         check("m_done",     done,       m_done);
         check("m_src",      active_src, m_src);
         check("m_hi_ready", hi_ready,   rst_n && !m_play);
         check("m_lo_ready", lo_ready,   rst_n && !m_play && !hi_valid);
      end
   end

   task automatic send(input bit hi, input logic [3:0] n, output time t_acc);
      bit got;
      got = 0; t_acc = 0;
      @(negedge clk);
      if (hi) begin hi_valid = 1; hi_count = n; end
      else    begin lo_valid = 1; lo_count = n; end
      for (int i = 0; i < 400 && !got; i++) begin
         #1;
         if ((hi ? hi_ready : lo_ready) === 1'b1) begin
            @(posedge clk); #1; t_acc = $time; got = 1;
         end else begin
            @(negedge clk);
         end
      end
      check("accept", got, 1);
      @(negedge clk);
      if (hi) hi_valid = 0; else lo_valid = 0;
   endtask

   task automatic wait_done(input time t_acc, output int dclk, output int ledn);
      bit seen;
      seen = 0; dclk = -1;
      ledn = int'(led);
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            seen = 1;
            dclk = int'(($time - t_acc) / 10);
         end else begin
            ledn += int'(led);
         end
      end
      check("done_seen", seen, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      time t;
      int  dclk, ledn, cnt;

      repeat (3) @(negedge clk);
      check("rst_led", led, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_src", active_src, 0);
      check("rst_hi_ready", hi_ready, 0);
      rst_n = 1; #1;
      check("idle_hi_ready", hi_ready, 1);

      // lo N=3: 8/4/8/4/8 then 12 dark, done 44 clk after accept
      send(0, 4'd3, t);
      wait_done(t, dclk, ledn);
      check("t1_dur", dclk, 44);
      check("t1_led_cycles", ledn, 24);
      check("t1_src", active_src, 0);
      @(posedge clk); #1;
      check("t1_done_once", done, 0);

      // hi N=2 and lo N=1 together: hi first, lo taken in hi's done cycle
      @(negedge clk);
      hi_valid = 1; hi_count = 4'd2; lo_valid = 1; lo_count = 4'd1; #1;
      check("t2_hi_ready", hi_ready, 1);
      check("t2_lo_ready", lo_ready, 0);
      @(posedge clk); #1; t = $time;
      check("t2_src_hi", active_src, 1);
      @(negedge clk); hi_valid = 0;
      wait_done(t, dclk, ledn);
      check("t2_hi_dur", dclk, 32);
      check("t2_hi_led", ledn, 16);
      check("t2_lo_ready_done", lo_ready, 1);
      @(posedge clk); #1; t = $time;
      check("t2_src_lo", active_src, 0);
      check("t2_lo_led", led, 1);
      @(negedge clk); lo_valid = 0;
      wait_done(t, dclk, ledn);
      check("t2_lo_dur", dclk, 20);

      // hi N=1: one 8-clk pulse, 12-clk gap
      send(1, 4'd1, t);
      wait_done(t, dclk, ledn);
      check("t4_dur", dclk, 20);
      check("t4_led_cycles", ledn, 8);
      check("t4_src", active_src, 1);

      // lo N=0: accepted and discarded
      send(0, 4'd0, t);
      cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         cnt += int'(led) + int'(busy) + int'(done);
      end
      check("t3_quiet", cnt, 0);
      check("t3_src", active_src, 0);

      // lo N=5, reset during the second ON phase, then a fresh code
      send(0, 4'd5, t);
      check("t5_first_on", led, 1);
      repeat (14) @(negedge clk);
      check("t5_second_on", led, 1);
      rst_n = 0;
      @(negedge clk); rst_n = 1; #1;
      check("t5_led_abort", led, 0);
      check("t5_busy_abort", busy, 0);
      check("t5_ready_after", hi_ready, 1);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         cnt += int'(done);
      end
      check("t5_no_done", cnt, 0);
      send(0, 4'd1, t);
      wait_done(t, dclk, ledn);
      check("t5_new_dur", dclk, 20);
      check("t5_new_led", ledn, 8);

      // hi N=15 with lo held: lo waits 188 clk
      @(negedge clk);
      hi_valid = 1; hi_count = 4'd15; lo_valid = 1; lo_count = 4'd2;
      @(posedge clk); #1;
      @(negedge clk); hi_valid = 0;
      cnt = (lo_ready === 1'b0) ? 1 : 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (lo_ready === 1'b1) break;
         cnt++;
      end
      check("t6_lo_wait", cnt, 188);
      check("t6_done_at_ready", done, 1);
      @(posedge clk); #1; t = $time;
      check("t6_src_lo", active_src, 0);
      @(negedge clk); lo_valid = 0;
      wait_done(t, dclk, ledn);
      check("t6_lo_dur", dclk, 32);
      check("t6_lo_led", ledn, 16);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
